// File: rtl/bf16_adder.sv
// bf16_adder: bfloat16 adder, z = a + b, round-to-nearest-even, one-cycle latency.
// Format: {sign, exp[7:0] (bias 127), frac[6:0]}. Subnormal inputs are treated
// as signed zero, and results that underflow are flushed to signed zero.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears z and z_vld)
//   a      operand A, a_vld qualifies it
//   b      operand B, b_vld qualifies it
//   z      registered sum, updated only when a_vld & b_vld
//   z_vld  registered a_vld & b_vld
module bf16_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic        a_vld,
    input  logic [15:0] b,
    input  logic        b_vld,
    output logic [15:0] z,
    output logic        z_vld
);

    localparam logic [15:0] QNAN = 16'h7FC0;

    // ------------------------------------------------------------------
    // Unpack and classify
    // ------------------------------------------------------------------
    logic       sa, sb;
    logic [7:0] ea, eb;
    logic [6:0] fa, fb;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign a_nan  = (ea == 8'hFF) && (fa != 7'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 7'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 7'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 7'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    // ------------------------------------------------------------------
    // Order by magnitude; {exp,frac} compares as an unsigned integer
    // ------------------------------------------------------------------
    logic       a_ge;
    logic       s_l;
    logic [7:0] e_l, e_s;
    logic [7:0] m_l, m_s;
    logic [7:0] diff;
    logic       eff_sub;

    assign a_ge    = (a[14:0] >= b[14:0]);
    assign s_l     = a_ge ? sa : sb;
    assign e_l     = a_ge ? ea : eb;
    assign e_s     = a_ge ? eb : ea;
    assign m_l     = {1'b1, (a_ge ? fa : fb)};
    assign m_s     = {1'b1, (a_ge ? fb : fa)};
    assign diff    = e_l - e_s;
    assign eff_sub = sa ^ sb;

    // ------------------------------------------------------------------
    // Align the smaller significand. With a shift of at most 10 the
    // 18-bit window keeps every shifted-out bit, so the low byte is
    // exactly the sticky field. Beyond 10 only sticky survives.
    // ------------------------------------------------------------------
    logic [17:0] sh_ext;
    logic [9:0]  s_align;
    logic        s_sticky;

    assign sh_ext = {m_s, 10'b0} >> diff;

    always_comb begin
        s_align  = sh_ext[17:8];
        s_sticky = |sh_ext[7:0];
        if (diff > 8'd10) begin
            s_align  = 10'd0;
            s_sticky = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Add / subtract in {carry, sig[7:0], guard, round, sticky}.
    // Sticky as a real LSB makes the subtraction borrow come out right
    // for round-to-nearest; sticky is only ever set when diff >= 2, and
    // then at most one bit of left normalization is needed.
    // ------------------------------------------------------------------
    logic [11:0] op_l, op_s, sum;

    assign op_l = {1'b0, m_l, 3'b000};
    assign op_s = {1'b0, s_align, s_sticky};
    assign sum  = eff_sub ? (op_l - op_s) : (op_l + op_s);

    // Leading-zero count over sum[10:0]; 11 means all zero
    logic [3:0] lzc;

    always_comb begin
        lzc = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (sum[i]) lzc = 4'(10 - i);
        end
    end

    // ------------------------------------------------------------------
    // Normalize; exponent is kept 10-bit signed so over/underflow
    // checks cannot wrap
    // ------------------------------------------------------------------
    logic [10:0]       nm;
    logic signed [9:0] e_norm;

    always_comb begin
        if (sum[11]) begin
            nm     = {sum[11:2], |sum[1:0]};
            e_norm = $signed({2'b00, e_l}) + 10'sd1;
        end else begin
            nm     = sum[10:0] << lzc;
            e_norm = $signed({2'b00, e_l}) - $signed({6'b0, lzc});
        end
    end

    // ------------------------------------------------------------------
    // Round to nearest even
    // ------------------------------------------------------------------
    logic              rnd_inc;
    logic [8:0]        rnd;
    logic signed [9:0] e_fin;
    logic [6:0]        f_fin;

    assign rnd_inc = nm[2] & (nm[1] | nm[0] | nm[3]);
    assign rnd     = {1'b0, nm[10:3]} + {8'd0, rnd_inc};
    // rounding carry gives 1.0000000 x 2 -> renormalize
    assign e_fin   = e_norm + $signed({9'd0, rnd[8]});
    assign f_fin   = rnd[8] ? rnd[7:1] : rnd[6:0];

    // ------------------------------------------------------------------
    // Result select, specials first
    // ------------------------------------------------------------------
    logic [15:0] res;

    always_comb begin
        res = {s_l, e_fin[7:0], f_fin};
        if (a_nan || b_nan) begin
            res = QNAN;
        end else if (a_inf && b_inf) begin
            res = (sa != sb) ? QNAN : a;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if (a_zero && b_zero) begin
            res = {(sa & sb), 15'd0};
        end else if (a_zero) begin
            res = b;
        end else if (b_zero) begin
            res = a;
        end else if (eff_sub && (a[14:0] == b[14:0])) begin
            res = 16'h0000;
        end else if (e_fin >= 10'sd255) begin
            res = {s_l, 8'hFF, 7'd0};
        end else if (e_fin <= 10'sd0) begin
            res = {s_l, 15'd0};
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z     <= 16'h0000;
            z_vld <= 1'b0;
        end else begin
            z_vld <= a_vld & b_vld;
            if (a_vld & b_vld) z <= res;
        end
    end

endmodule

// File: tb/tb_bf16_adder.sv
// Self-checking bench for bf16_adder: directed corner vectors plus random
// streams checked against a real-arithmetic reference model.
module tb_bf16_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = 16'h0;
    logic        a_vld = 1'b0;
    logic [15:0] b = 16'h0;
    logic        b_vld = 1'b0;
    logic [15:0] z;
    logic        z_vld;

    bf16_adder dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .a_vld(a_vld),
        .b    (b),
        .b_vld(b_vld),
        .z    (z),
        .z_vld(z_vld)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_z = 16'h0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] z;
    } vec_t;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int n);
        real r = 1.0;
        for (int i = 0; i < n; i++) r = r * 2.0;
        for (int i = 0; i > n; i--) r = r / 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [15:0] v);
        real r;
        if (v[14:7] == 8'd0) return 0.0;
        r = real'({1'b1, v[6:0]}) * pow2(int'(v[14:7]) - 134);
        return v[15] ? -r : r;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        logic xn, yn, xi, yi, xz, yz, sg;
        real  s, m, rem;
        int   e, mi;
        xn = (x[14:7] == 8'hFF) && (x[6:0] != 0);
        yn = (y[14:7] == 8'hFF) && (y[6:0] != 0);
        xi = (x[14:7] == 8'hFF) && (x[6:0] == 0);
        yi = (y[14:7] == 8'hFF) && (y[6:0] == 0);
        xz = (x[14:7] == 8'h00);
        yz = (y[14:7] == 8'h00);
        if (xn || yn) return 16'h7FC0;
        if (xi && yi) return (x[15] != y[15]) ? 16'h7FC0 : x;
        if (xi) return x;
        if (yi) return y;
        if (xz && yz) return {x[15] & y[15], 15'd0};
        if (xz) return y;
        if (yz) return x;
        s = to_real(x) + to_real(y);
        if (s == 0.0) return 16'h0000;
        sg = (s < 0.0);
        m  = sg ? -s : s;
        e  = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        m   = m * 128.0;
        mi  = $rtoi(m);
        rem = m - $itor(mi);
        if (rem > 0.5 || (rem == 0.5 && mi[0])) mi++;
        if (mi == 256) begin mi = 128; e++; end
        e = e + 127;
        if (e >= 255) return {sg, 8'hFF, 7'd0};
        if (e <= 0)   return {sg, 15'd0};
        return {sg, e[7:0], mi[6:0]};
    endfunction

    // Apply one vector, clock it, check the registered result right after.
    task automatic step(input logic [15:0] ai, input logic [15:0] bi,
                        input logic av, input logic bv,
                        input logic [15:0] want, input string tag);
        a = ai; b = bi; a_vld = av; b_vld = bv;
        @(posedge clk); #1;
        chk({tag, ".vld"}, {15'd0, z_vld}, {15'd0, av & bv});
        if (av & bv) exp_z = want;
        chk(tag, z, exp_z);
    endtask

    logic [15:0] specials [12] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0,
                                   16'hFFC1, 16'h0001, 16'h7F7F, 16'hFF7F, 16'h0080,
                                   16'h8080, 16'h3F80};

    vec_t dv [19];

    initial begin
        logic [15:0] ra, rb;
        logic        av, bv;
        int          e;

        dv = '{'{16'h3F80, 16'h3F80, 16'h4000}, '{16'h623C, 16'h623C, 16'h62BC},
               '{16'h1B74, 16'h1A64, 16'h1B96}, '{16'h3F80, 16'h3B80, 16'h3F80},
               '{16'h3F81, 16'h3B80, 16'h3F82}, '{16'h3F80, 16'hBF80, 16'h0000},
               '{16'h8000, 16'h8000, 16'h8000}, '{16'h4040, 16'hBF80, 16'h4000},
               '{16'h7F7F, 16'h7F7F, 16'h7F80}, '{16'h7F80, 16'hFF80, 16'h7FC0},
               '{16'h7FC1, 16'h3F80, 16'h7FC0}, '{16'hFF80, 16'h3F80, 16'hFF80},
               '{16'h0001, 16'h3F80, 16'h3F80}, '{16'h8000, 16'h0000, 16'h0000},
               '{16'h0081, 16'h8080, 16'h0000}, '{16'h8081, 16'h0080, 16'h8000},
               '{16'h3F80, 16'h3380, 16'h3F80}, '{16'h3F80, 16'hB380, 16'h3F80},
               '{16'hFF7F, 16'hFF7F, 16'hFF80}};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.z", z, 16'h0000);
        chk("rst.vld", {15'd0, z_vld}, 16'h0000);
        rst_n = 1'b1;

        // directed vectors, streamed back-to-back
        foreach (dv[i]) step(dv[i].a, dv[i].b, 1'b1, 1'b1, dv[i].z, $sformatf("dir%0d", i));

        // valid gating: z must hold
        step(16'h4040, 16'h4040, 1'b1, 1'b0, 16'h0000, "gate_a");
        step(16'h4040, 16'h4040, 1'b0, 1'b1, 16'h0000, "gate_b");
        step(16'h4040, 16'h4040, 1'b1, 1'b1, 16'h40C0, "gate_ok");

        // random stream
        for (int n = 0; n < 3000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ;
                1, 2, 3, 4: begin
                    ra[14:7] = 8'($urandom_range(1, 254));
                    e = int'(ra[14:7]) + int'($urandom_range(0, 24)) - 12;
                    if (e < 1) e = 1;
                    if (e > 254) e = 254;
                    rb[14:7] = e[7:0];
                end
                5: begin
                    ra[14:7] = 8'($urandom_range(1, 254));
                    rb = ra ^ 16'h8000;
                    rb[2:0] = 3'($urandom);
                end
                6: begin
                    ra = specials[$urandom_range(0, 11)];
                    if ($urandom_range(0, 1) == 1) rb = specials[$urandom_range(0, 11)];
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        ra[14:7] = 8'($urandom_range(248, 254));
                        rb[14:7] = 8'($urandom_range(248, 254));
                    end else begin
                        ra[14:7] = 8'($urandom_range(1, 6));
                        rb[14:7] = 8'($urandom_range(1, 6));
                    end
                end
            endcase
            av = ($urandom_range(0, 9) != 0);
            bv = ($urandom_range(0, 9) != 0);
            step(ra, rb, av, bv, ref_add(ra, rb), "rand");
        end

        // asynchronous reset mid-stream with both valids high
        a = 16'h3F80; b = 16'h3F80; a_vld = 1'b1; b_vld = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.z", z, 16'h0000);
        chk("arst.vld", {15'd0, z_vld}, 16'h0000);
        @(posedge clk); #1;
        chk("arst_hold.z", z, 16'h0000);
        chk("arst_hold.vld", {15'd0, z_vld}, 16'h0000);
        #2 rst_n = 1'b1;
        exp_z = 16'h0000;
        #1;
        step(16'h3F80, 16'h3F80, 1'b1, 1'b1, 16'h4000, "rst_rel");
        step(16'h4040, 16'hBF80, 1'b1, 1'b1, 16'h4000, "rst_rel2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bf16_adder.md
Name: bf16_adder

Overview:
- Single-precision-reduced floating-point adder for bfloat16 operands (1 sign, 8 exponent bits with bias 127, 7 fraction bits).
- Computes z = a + b with IEEE-754 round-to-nearest-even.
- Registered output, one-cycle latency, simple valid qualifiers.
- Used as the addition node in the probabilistic-circuit datapath.

Parameters:
- none (format fixed to bf16: EXP_W=8, FRAC_W=7, bias 127)

Ports:
- clk    input   1   rising-edge clock
- rst_n  input   1   asynchronous active-low reset
- a      input   16  operand A, bf16 {sign, exp[7:0], frac[6:0]}
- a_vld  input   1   operand A valid
- b      input   16  operand B, bf16
- b_vld  input   1   operand B valid
- z      output  16  registered sum, bf16
- z_vld  output  1   registered result valid

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, z=16'h0000 and z_vld=0, asynchronously. Normal operation resumes at the first rising clk edge after rst_n deasserts.
- Handshake: no backpressure.
  - On each rising edge, z_vld <= a_vld & b_vld.
  - When a_vld & b_vld=1, z <= round(a+b) for the a/b present before that edge.
  - Otherwise z holds its previous value.
- Latency: exactly 1 cycle. Throughput: 1 result per cycle. Back-to-back operands produce back-to-back results.
- Datapath (combinational, ahead of the output register):
  - Unpack: significand = {hidden 1, frac} for exp≠0.
  - Subnormals: exp=0 is treated as ±0 (flush-to-zero on input).
  - Order the operands by magnitude (exponent, then significand). The larger operand sets the result sign and the preliminary exponent.
  - Align: right-shift the smaller significand by the exponent difference (8-bit unsigned). Keep guard and round bits, and OR every further shifted-out bit into sticky. A difference above 10 makes the smaller operand contribute sticky only.
  - Add significands on equal signs; subtract smaller from larger on unequal signs.
  - Normalize on carry-out: shift right 1, exponent+1, shifted-out bit merges into guard/round/sticky.
  - Normalize on leading zeros after subtraction: count leading zeros (0..10), shift left, decrement exponent.
  - Round to nearest even: increment if guard & (round | sticky | lsb). A rounding carry renormalizes (exponent+1).
- Special cases, highest priority first:
  - Any NaN operand (exp=FF, frac≠0) → 16'h7FC0.
  - +Inf + -Inf → 16'h7FC0.
  - Inf ± finite → that Inf. Same-sign Infs → that Inf.
  - Exact cancellation (equal magnitude, opposite sign) → +0 (16'h0000).
  - -0 + -0 → 16'h8000. Any other zero combination → the other operand (+0 if both zero).
  - Result exponent ≥ 255 after rounding → ±Inf (exp=FF, frac=0).
  - Result exponent ≤ 0 (underflow) → ±0 with the result sign (flush-to-zero on output).
- Exponent arithmetic uses ≥10-bit signed internal width so overflow and underflow detection cannot wrap.

Test Plan:
- Reset: assert rst_n=0 mid-stream with a_vld=b_vld=1 → z=0000 and z_vld=0 immediately. Deassert → the first valid result appears 1 cycle later.
- Basic and exponent bump:
  - a=3F80, b=3F80 → z=4000.
  - a=623C, b=623C → z=62BC.
  - z_vld=1 one cycle after inputs, with back-to-back vectors streaming each cycle.
- Alignment and rounding:
  - a=1B74, b=1A64 → z=1B96 (carry-out, tie, lsb even, no increment).
  - a=3F80, b=3B80 → 3F80 (tie to even).
  - a=3F81, b=3B80 → 3F82 (tie rounds up).
- Cancellation and signed zero:
  - a=3F80, b=BF80 → 0000.
  - a=8000, b=8000 → 8000.
  - a=4040, b=BF80 → 4000 (3-1, leading-zero normalize).
- Specials:
  - a=7F7F, b=7F7F → 7F80 (overflow).
  - a=7F80, b=FF80 → 7FC0.
  - a=7FC1, b=3F80 → 7FC0.
  - a=FF80, b=3F80 → FF80.
  - a=0001 (subnormal), b=3F80 → 3F80.
- Valid gating: a_vld=1, b_vld=0 with new operands → z_vld=0 next cycle and z holds its prior value.
